// File: rtl/ft_cmd_pkg.sv
// Shared constants, state encoding and helpers for the FT245 host command parser.
package ft_cmd_pkg;

    localparam logic [7:0] SYNC_RX   = 8'hA5;
    localparam logic [7:0] SYNC_TX   = 8'h5A;

    localparam logic [7:0] OPC_WR    = 8'h01;
    localparam logic [7:0] OPC_RD    = 8'h02;

    localparam logic [7:0] ST_OK     = 8'h00;
    localparam logic [7:0] ST_BADCHK = 8'h01;
    localparam logic [7:0] ST_BADOPC = 8'h02;

    typedef enum logic [2:0] {
        HUNT      = 3'd0,
        RX_FIELDS = 3'd1,
        EXEC      = 3'd2,
        RD_WAIT   = 3'd3,
        TX_RESP   = 3'd4
    } state_t;

    // Error counter increment that sticks at FF instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/ft_cmd_resp_tx.sv
// Serializes the fixed 5-byte response frame (5A, STATUS, ADDR, RH, RL) into the
// tx FIFO. The byte on o_tx_wdata only advances after it has actually been pushed,
// so a full FIFO stalls the stream without dropping or repeating bytes.
module ft_cmd_resp_tx
    import ft_cmd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic [7:0] i_status,
    input  logic [7:0] i_addr,
    input  logic [7:0] i_rh,
    input  logic [7:0] i_rl,
    input  logic       i_tx_wfull,
    output logic [7:0] o_tx_wdata,
    output logic       o_tx_winc,
    output logic       o_done
);

    logic       r_active;
    logic [2:0] r_tidx;
    logic [7:0] r_data;
    logic [7:0] r_status;
    logic [7:0] r_addr;
    logic [7:0] r_rh;
    logic [7:0] r_rl;
    logic       w_push;
    logic [7:0] w_next;

    assign w_push     = r_active && !i_tx_wfull;
    assign o_tx_winc  = w_push;
    assign o_done     = w_push && (r_tidx == 3'd4);
    assign o_tx_wdata = r_data;

    // Byte that follows the one currently presented.
    always_comb begin
        w_next = 8'h00;
        case (r_tidx)
            3'd0:    w_next = r_status;
            3'd1:    w_next = r_addr;
            3'd2:    w_next = r_rh;
            3'd3:    w_next = r_rl;
            default: w_next = 8'h00;
        endcase
    end

    // Load the frame on start, then step one byte per accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active <= 1'b0;
            r_tidx   <= 3'd0;
            r_data   <= 8'h00;
            r_status <= 8'h00;
            r_addr   <= 8'h00;
            r_rh     <= 8'h00;
            r_rl     <= 8'h00;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_tidx   <= 3'd0;
            r_data   <= SYNC_TX;
            r_status <= i_status;
            r_addr   <= i_addr;
            r_rh     <= i_rh;
            r_rl     <= i_rl;
        end else if (w_push) begin
            if (r_tidx == 3'd4) begin
                r_active <= 1'b0;
                r_tidx   <= 3'd0;
                r_data   <= 8'h00;
            end else begin
                r_tidx   <= r_tidx + 3'd1;
                r_data   <= w_next;
            end
        end
    end

endmodule

// File: rtl/ft_cmd_parser.sv
// Host command decoder: pops 6-byte frames (A5 OPC ADDR DH DL CHK) from the rx FIFO,
// runs a register write/read and answers with a 5-byte frame into the tx FIFO.
//
//  state     | meaning
//  ----------+--------------------------------------------------------------
//  HUNT      | discard bytes until sync A5 is popped
//  RX_FIELDS | capture OPC, ADDR, DH, DL, CHK; drop frame on inter-byte timeout
//  EXEC      | check checksum/opcode, fire reg_wr or reg_rd, set STATUS
//  RD_WAIT   | pick RH/RL (read data or echo), start the response serializer
//  TX_RESP   | wait until all 5 response bytes are pushed
module ft_cmd_parser
    import ft_cmd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int ADDR_W         = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_rdata,
    input  logic              rx_rempty,
    output logic              rx_rinc,
    output logic [7:0]        tx_wdata,
    input  logic              tx_wfull,
    output logic              tx_winc,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [15:0]       reg_wdata,
    output logic              reg_wr,
    output logic              reg_rd,
    input  logic [15:0]       reg_rdata,
    output logic              busy,
    output logic [7:0]        err_count
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    state_t        r_state;
    logic [2:0]    r_idx;
    logic [TW-1:0] r_tcnt;
    logic [7:0]    r_opc;
    logic [7:0]    r_addr;
    logic [7:0]    r_dh;
    logic [7:0]    r_dl;
    logic [7:0]    r_chk;
    logic [7:0]    r_status;
    logic          r_rd_ok;

    logic          w_pop;
    logic          w_chk_ok;
    logic          w_tx_start;
    logic          w_tx_done;
    logic [7:0]    w_rh;
    logic [7:0]    w_rl;

    assign w_pop      = ((r_state == HUNT) || (r_state == RX_FIELDS)) && !rx_rempty;
    assign rx_rinc    = w_pop;
    assign w_chk_ok   = ((r_opc ^ r_addr ^ r_dh ^ r_dl) == r_chk);
    assign w_tx_start = (r_state == RD_WAIT);
    // reg_rd was raised on entry to RD_WAIT, so reg_rdata is valid this cycle.
    assign w_rh       = r_rd_ok ? reg_rdata[15:8] : r_dh;
    assign w_rl       = r_rd_ok ? reg_rdata[7:0]  : r_dl;

    ft_cmd_resp_tx u_resp_tx (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_start    (w_tx_start),
        .i_status   (r_status),
        .i_addr     (r_addr),
        .i_rh       (w_rh),
        .i_rl       (w_rl),
        .i_tx_wfull (tx_wfull),
        .o_tx_wdata (tx_wdata),
        .o_tx_winc  (tx_winc),
        .o_done     (w_tx_done)
    );

    // Frame capture, timeout, evaluation and registered bus/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= HUNT;
            r_idx     <= 3'd0;
            r_tcnt    <= '0;
            r_opc     <= 8'h00;
            r_addr    <= 8'h00;
            r_dh      <= 8'h00;
            r_dl      <= 8'h00;
            r_chk     <= 8'h00;
            r_status  <= 8'h00;
            r_rd_ok   <= 1'b0;
            reg_addr  <= '0;
            reg_wdata <= 16'h0000;
            reg_wr    <= 1'b0;
            reg_rd    <= 1'b0;
            busy      <= 1'b0;
            err_count <= 8'h00;
        end else begin
            reg_wr <= 1'b0;
            reg_rd <= 1'b0;
            case (r_state)
                HUNT: begin
                    if (w_pop && (rx_rdata == SYNC_RX)) begin
                        r_state <= RX_FIELDS;
                        r_idx   <= 3'd0;
                        r_tcnt  <= '0;
                        busy    <= 1'b1;
                    end
                end
                RX_FIELDS: begin
                    if (w_pop) begin
                        r_tcnt <= '0;
                        r_idx  <= r_idx + 3'd1;
                        case (r_idx)
                            3'd0:    r_opc  <= rx_rdata;
                            3'd1:    r_addr <= rx_rdata;
                            3'd2:    r_dh   <= rx_rdata;
                            3'd3:    r_dl   <= rx_rdata;
                            default: r_chk  <= rx_rdata;
                        endcase
                        if (r_idx == 3'd4) begin
                            r_state <= EXEC;
                        end
                    // The idle count would reach TIMEOUT_CYCLES on this edge.
                    end else if (r_tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        r_state   <= HUNT;
                        r_tcnt    <= '0;
                        busy      <= 1'b0;
                        err_count <= sat_inc8(err_count);
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                EXEC: begin
                    reg_addr  <= ADDR_W'(r_addr);
                    reg_wdata <= {r_dh, r_dl};
                    r_rd_ok   <= 1'b0;
                    if (!w_chk_ok) begin
                        r_status  <= ST_BADCHK;
                        err_count <= sat_inc8(err_count);
                    end else if (r_opc == OPC_WR) begin
                        r_status <= ST_OK;
                        reg_wr   <= 1'b1;
                    end else if (r_opc == OPC_RD) begin
                        r_status <= ST_OK;
                        reg_rd   <= 1'b1;
                        r_rd_ok  <= 1'b1;
                    end else begin
                        r_status  <= ST_BADOPC;
                        err_count <= sat_inc8(err_count);
                    end
                    r_state <= RD_WAIT;
                end
                RD_WAIT: begin
                    r_state <= TX_RESP;
                end
                TX_RESP: begin
                    if (w_tx_done) begin
                        r_state <= HUNT;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= HUNT;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ft_cmd_parser.sv
// Directed bench for ft_cmd_parser: FWFT rx FIFO model, tx capture queue and a
// register file model that answers reg_rd with BEEF in the strobe cycle.
module tb_ft_cmd_parser;

    localparam int TMO = 65535;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_rdata = 8'h00;
    logic        rx_rempty = 1'b1;
    logic        rx_rinc;
    logic [7:0]  tx_wdata;
    logic        tx_wfull = 1'b0;
    logic        tx_winc;
    logic [7:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic        reg_wr;
    logic        reg_rd;
    logic [15:0] reg_rdata = 16'h0000;
    logic        busy;
    logic [7:0]  err_count;

    logic [7:0]  rx_q[$];
    logic [7:0]  tx_q[$];

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0, pop_cnt = 0, pop_cyc = 0;
    int wr_cnt = 0, wr_cyc = 0, rd_cnt = 0, tx_first_cyc = 0;
    logic [7:0]  wr_addr = 8'h00;
    logic [15:0] wr_data = 16'h0000;

    always #5 clk = ~clk;

    ft_cmd_parser dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx_rdata  (rx_rdata),
        .rx_rempty (rx_rempty),
        .rx_rinc   (rx_rinc),
        .tx_wdata  (tx_wdata),
        .tx_wfull  (tx_wfull),
        .tx_winc   (tx_winc),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_wr    (reg_wr),
        .reg_rd    (reg_rd),
        .reg_rdata (reg_rdata),
        .busy      (busy),
        .err_count (err_count)
    );

    // Edge monitor: rx pops, bus strobes and tx pushes as seen by the DUT.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rx_rinc && rx_q.size() > 0) begin
            void'(rx_q.pop_front());
            pop_cnt = pop_cnt + 1;
            pop_cyc = cyc;
        end
        if (reg_wr) begin
            wr_cnt  = wr_cnt + 1;
            wr_cyc  = cyc;
            wr_addr = reg_addr;
            wr_data = reg_wdata;
        end
        if (reg_rd) rd_cnt = rd_cnt + 1;
        if (tx_winc) begin
            if (tx_q.size() == 0) tx_first_cyc = cyc;
            tx_q.push_back(tx_wdata);
        end
    end

    // FIFO head and register file read data, updated away from the active edge.
    always @(negedge clk) begin
        rx_rempty = (rx_q.size() == 0);
        rx_rdata  = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
        reg_rdata = reg_rd ? 16'hBEEF : 16'hDEAD;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame(input logic [7:0] b0, b1, b2, b3, b4, b5);
        rx_q.push_back(b0); rx_q.push_back(b1); rx_q.push_back(b2);
        rx_q.push_back(b3); rx_q.push_back(b4); rx_q.push_back(b5);
    endtask

    task automatic wait_tx(input int n);
        int k = 0;
        while (tx_q.size() < n && k < 400) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic check_resp(input string tag, input logic [7:0] st, ad, rh, rl);
        logic [7:0] exp [5];
        exp[0] = 8'h5A; exp[1] = st; exp[2] = ad; exp[3] = rh; exp[4] = rl;
        wait_tx(5);
        check({tag, " tx count"}, tx_q.size(), 5);
        for (int i = 0; i < 5; i++)
            check($sformatf("%s tx byte%0d", tag, i),
                  (i < tx_q.size()) ? {24'h0, tx_q[i]} : 32'hFFFF_FFFF, {24'h0, exp[i]});
        check({tag, " idle after resp"}, busy, 0);
    endtask

    initial begin
        int base;
        int k;
        int stall_bad;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst busy", busy, 0);
        check("rst err_count", err_count, 0);
        check("rst reg_wr", reg_wr, 0);
        check("rst reg_rd", reg_rd, 0);
        check("rst reg_addr", reg_addr, 0);
        check("rst reg_wdata", reg_wdata, 0);
        check("rst tx_winc", tx_winc, 0);
        check("rst tx_wdata", tx_wdata, 0);
        check("rst rx_rinc", rx_rinc, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset mid-frame: partial frame dropped, nothing sent
        rx_q.push_back(8'hA5); rx_q.push_back(8'h01); rx_q.push_back(8'h10);
        base = 0; k = 0;
        while (pop_cnt < 3 && k < 50) begin @(negedge clk); k++; end
        check("midrst busy before", busy, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("midrst busy", busy, 0);
        check("midrst no tx", tx_q.size(), 0);
        check("midrst no wr", wr_cnt, 0);

        // Write frame; CHK = 01^10^12^34 = 37
        push_frame(8'hA5, 8'h01, 8'h10, 8'h12, 8'h34, 8'h37);
        check_resp("wr", 8'h00, 8'h10, 8'h12, 8'h34);
        check("wr strobes", wr_cnt, 1);
        check("wr addr", wr_addr, 8'h10);
        check("wr data", wr_data, 16'h1234);
        check("wr strobe latency", wr_cyc - pop_cyc, 2);
        check("wr first tx latency", tx_first_cyc - pop_cyc, 3);
        check("wr no rd", rd_cnt, 0);
        check("wr err_count", err_count, 0);
        tx_q.delete();

        // Read frame
        push_frame(8'hA5, 8'h02, 8'h20, 8'h00, 8'h00, 8'h22);
        check_resp("rd", 8'h00, 8'h20, 8'hBE, 8'hEF);
        check("rd strobes", rd_cnt, 1);
        check("rd no wr", wr_cnt, 1);
        tx_q.delete();

        // Bad checksum
        push_frame(8'hA5, 8'h01, 8'h10, 8'h12, 8'h34, 8'h00);
        check_resp("badchk", 8'h01, 8'h10, 8'h12, 8'h34);
        check("badchk no wr", wr_cnt, 1);
        check("badchk err_count", err_count, 1);
        tx_q.delete();

        // Garbage then bad opcode; CHK = 03^40^AB^CD = 25
        rx_q.push_back(8'h00); rx_q.push_back(8'hFF);
        push_frame(8'hA5, 8'h03, 8'h40, 8'hAB, 8'hCD, 8'h25);
        check_resp("badopc", 8'h02, 8'h40, 8'hAB, 8'hCD);
        check("badopc no strobes", wr_cnt + rd_cnt, 2);
        check("badopc err_count", err_count, 2);
        tx_q.delete();

        // Timeout after A5 01
        base = pop_cnt; k = 0;
        rx_q.push_back(8'hA5); rx_q.push_back(8'h01);
        while (pop_cnt < base + 2 && k < 50) begin @(negedge clk); k++; end
        check("tmo pops", pop_cnt, base + 2);
        repeat (TMO - 1) @(negedge clk);
        check("tmo busy one clk before", busy, 1);
        check("tmo err before", err_count, 2);
        @(negedge clk);
        check("tmo busy after", busy, 0);
        check("tmo err_count", err_count, 3);
        check("tmo no tx", tx_q.size(), 0);
        push_frame(8'hA5, 8'h01, 8'h10, 8'h12, 8'h34, 8'h37);
        check_resp("post tmo", 8'h00, 8'h10, 8'h12, 8'h34);
        check("post tmo wr", wr_cnt, 2);
        check("post tmo wdata", wr_data, 16'h1234);
        tx_q.delete();

        // tx backpressure with a second frame waiting; CHK = 01^55^66^77 = 45
        push_frame(8'hA5, 8'h01, 8'h55, 8'h66, 8'h77, 8'h45);
        push_frame(8'hA5, 8'h02, 8'h20, 8'h00, 8'h00, 8'h22);
        wait_tx(2);
        check("stall pre count", tx_q.size(), 2);
        tx_wfull = 1'b1;
        stall_bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rx_rinc !== 1'b0 || tx_winc !== 1'b0) stall_bad++;
        end
        check("stall rinc/winc low", stall_bad, 0);
        check("stall count held", tx_q.size(), 2);
        check("stall rx not popped", rx_q.size(), 6);
        tx_wfull = 1'b0;
        check_resp("stall", 8'h00, 8'h55, 8'h66, 8'h77);
        check("stall wr data", wr_data, 16'h6677);
        tx_q.delete();
        check_resp("queued rd", 8'h00, 8'h20, 8'hBE, 8'hEF);
        check("queued rd strobes", rd_cnt, 2);
        check("final err_count", err_count, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
